memory_port_arbiter: RTL and testbench
======================================

# memory_port_arbiter

Shares the single main-memory port between the instruction-fetch side and the data-cache refill/write-back side of the multicycle MIPS core. Each requester holds a level request. The arbiter grants one owner at a time with round-robin tie-breaking and sequences a fixed-latency memory access. It returns read data with a one-cycle done pulse, which replaces the ad-hoc wait states in the cache controller.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- MEM_LATENCY, 4, memory access cycles (≥1); mem_rdata is valid in the last of these cycles

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- i_req  in  1  instruction-side read request (level)
- i_addr  in  ADDR_WIDTH  instruction-side address
- i_grant  out  1  instruction side owns the port
- i_done  out  1  one-cycle pulse; i_rdata is valid
- i_rdata  out  DATA_WIDTH  read data
- d_req  in  1  data-side request (level)
- d_we  in  1  1 = write-back, 0 = refill read
- d_addr  in  ADDR_WIDTH  data-side address
- d_wdata  in  DATA_WIDTH  write data
- d_grant  out  1  data side owns the port
- d_done  out  1  one-cycle pulse; access complete, d_rdata valid for reads
- d_rdata  out  DATA_WIDTH  read data
- mem_addr  out  ADDR_WIDTH  memory address
- mem_we  out  1  memory write strobe
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requesting: grant the requester that is not last_owner.
  - On grant: register owner, addr, we (forced to 0 for the I side) and wdata. Load cnt = MEM_LATENCY−1. Go to ACCESS. Update last_owner.
- ACCESS:
  - mem_addr and mem_wdata are driven from the captured registers.
  - mem_we = captured we in the first ACCESS cycle only, otherwise 0.
  - cnt decrements each cycle.
  - When cnt==0: capture mem_rdata into the rdata register and go to RESP.
- RESP: assert the owner's done for exactly one cycle, then return to IDLE.
- i_rdata and d_rdata are both driven from the shared rdata register. The value is meaningful only alongside the matching done pulse and is captured for writes too (content is don't-care).
- i_grant / d_grant: high in ACCESS and RESP while that side owns the port.
- Request protocol:
  - A requester holds req, addr, we and wdata stable until its done.
  - It must drop req in the cycle after done.
  - A req still high in IDLE counts as a new request.
  - Requests are ignored in ACCESS and RESP.
- Requests arriving mid-access are never lost; they wait in IDLE arbitration.
- mem_addr and mem_wdata hold the last captured values when idle. mem_we is 0 outside the first ACCESS cycle.

## Timing
- Reset values:
  - state = IDLE, last_owner = D, so the first tie goes to I.
  - All outputs 0: grants, dones, rdata, mem_addr, mem_we, mem_wdata, busy.
  - cnt = 0.
- Latency: req high in IDLE at cycle 0 → ACCESS in cycles 1..MEM_LATENCY → done in cycle MEM_LATENCY+1 (cycle 5 at default).
- The next grant comes no earlier than cycle MEM_LATENCY+2. Throughput is one access per MEM_LATENCY+2 cycles.
- Back-to-back ties alternate I, D, I, D.
- A sole continuous requester is re-granted each turn; there is no idle penalty beyond IDLE.
- rst in any state: IDLE on the next edge. No done pulse. No retry of the interrupted access, including a partially issued write. last_owner resets to D.
- MEM_LATENCY=1: ACCESS lasts one cycle. mem_we and the rdata capture occur in the same cycle.

## Test plan
- Single I read (MEM_LATENCY=4), i_req at cycle 0, i_addr=0x40, mem_rdata=0xDEADBEEF in cycle 4 → i_grant in cycles 1–5, mem_addr=0x40, i_done only in cycle 5 with i_rdata=0xDEADBEEF, d_done never.
- D write, d_addr=0x100, d_wdata=0x12345678 → mem_we=1 only in cycle 1 with matching addr/data, d_done in cycle 5, busy in cycles 1–5.
- i_req and d_req both raised at cycle 0 after reset and held → I granted first (done cycle 5), D granted at cycle 6 (done cycle 11), I again at cycle 12.
- d_req raised in cycle 2 during an I access → D granted in cycle 6 (the IDLE cycle after RESP), no loss, no overlap of grants.
- rst pulsed in cycle 2 of a D write → all outputs 0 on the next edge, no d_done, mem_we stays 0; a new i_req afterward completes normally.
- MEM_LATENCY=1 read → done in cycle 2, rdata equal to mem_rdata sampled in cycle 1.

Source files
------------

// File: rtl/memory_port_arbiter.sv
// Round-robin owner of the single main-memory port between I-fetch and D-cache.
// Fixed-latency access sequencer with a one-cycle done pulse per transfer.
module memory_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_grant,
    output logic                  i_done,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_grant,
    output logic                  d_done,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic                  we_q, we_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  busy_q, busy_d;
    logic                  i_grant_q, i_grant_d;
    logic                  d_grant_q, d_grant_d;
    logic                  i_done_q, i_done_d;
    logic                  d_done_q, d_done_d;
    logic                  pick_d;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        mem_we_d = 1'b0;
        // D wins only when alone or when I had the previous turn
        pick_d   = d_req && (!i_req || (last_q == OWN_I));
        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d  = ACCESS;
                    owner_d  = pick_d;
                    last_d   = pick_d;
                    addr_d   = pick_d ? d_addr : i_addr;
                    we_d     = pick_d && d_we;
                    wdata_d  = pick_d ? d_wdata : wdata_q;
                    cnt_d    = CNT_INIT;
                    mem_we_d = pick_d && d_we;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d    = (state_d != IDLE);
        i_grant_d = busy_d && (owner_d == OWN_I);
        d_grant_d = busy_d && (owner_d == OWN_D);
        i_done_d  = (state_d == RESP) && (owner_d == OWN_I);
        d_done_d  = (state_d == RESP) && (owner_d == OWN_D);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            last_q    <= OWN_D;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            mem_we_q  <= 1'b0;
            busy_q    <= 1'b0;
            i_grant_q <= 1'b0;
            d_grant_q <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            mem_we_q  <= mem_we_d;
            busy_q    <= busy_d;
            i_grant_q <= i_grant_d;
            d_grant_q <= d_grant_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
        end
    end

    assign i_grant   = i_grant_q;
    assign d_grant   = d_grant_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign i_rdata   = rdata_q;
    assign d_rdata   = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: latency-4 instance with a memory model and
// done scoreboard, plus a latency-1 instance driven directly.
module tb_memory_port_arbiter;

    localparam int LAT = 4;

    typedef struct {
        bit          side;
        bit          chk;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mem_clr;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_grant, i_done, d_grant, d_done, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    logic        i_req1, d_req1, d_we1;
    logic [31:0] i_addr1, d_addr1, d_wdata1, mem_rdata1;
    logic        i_grant1, i_done1, d_grant1, d_done1, mem_we1, busy1;
    logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1;

    memory_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant),
        .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    memory_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req1), .i_addr(i_addr1), .i_grant(i_grant1),
        .i_done(i_done1), .i_rdata(i_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_grant(d_grant1), .d_done(d_done1), .d_rdata(d_rdata1),
        .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    // Memory model: data only valid in the last access cycle
    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    int acnt = 0;
    int gcyc = 0;

    always @(posedge clk) gcyc <= gcyc + 1;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
            mem[16] <= 32'hDEADBEEF;
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
        if (busy && !i_done && !d_done) acnt <= acnt + 1;
        else acnt <= 0;
    end

    assign mem_rdata = (acnt == LAT - 1) ? mem[mem_addr[9:2]] : 32'hBAD0BAD0;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];

    // Advance one cycle and retire any done pulse against the scoreboard
    task automatic step();
        exp_t        e;
        logic [31:0] rd;
        @(negedge clk);
        if (i_done || d_done) begin
            checks++;
            if (sbq.size() == 0 || (i_done && d_done)) begin
                errors++;
                $display("FAIL done_unexpected cyc=%0d i_done=%0b d_done=%0b",
                         gcyc, i_done, d_done);
            end else begin
                e  = sbq.pop_front();
                rd = d_done ? d_rdata : i_rdata;
                if (d_done !== e.side || gcyc != e.cyc || (e.chk && rd !== e.data)) begin
                    errors++;
                    $display("FAIL done_match got side=%0b cyc=%0d data=%h want side=%0b cyc=%0d data=%h",
                             d_done, gcyc, rd, e.side, e.cyc, e.data);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_clr = 1'b1;
        step(); step();
        mem_clr = 1'b0;
        checks++;
        if ({i_grant, d_grant, i_done, d_done, mem_we, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl got=%b want=000000",
                     {i_grant, d_grant, i_done, d_done, mem_we, busy});
        end
        checks++;
        if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got=%h/%h want=0", i_rdata, d_rdata);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem got=%h/%h want=0", mem_addr, mem_wdata);
        end
        checks++;
        if ({i_grant1, d_grant1, i_done1, d_done1, mem_we1, busy1} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl1 got=%b want=000000",
                     {i_grant1, d_grant1, i_done1, d_done1, mem_we1, busy1});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        int g;
        g = gcyc;
        i_addr = 32'h40; i_req = 1'b1;
        sbq.push_back('{1'b0, 1'b1, ref_mem[16], g + 5});
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if ({i_grant, d_grant, busy, mem_we} !== {k <= 5, 1'b0, k <= 5, 1'b0}) begin
                errors++;
                $display("FAIL read_ctl k=%0d got=%b want=%b", k,
                         {i_grant, d_grant, busy, mem_we}, {k <= 5, 1'b0, k <= 5, 1'b0});
            end
            if (k == 2) begin
                checks++;
                if (mem_addr !== 32'h40) begin
                    errors++;
                    $display("FAIL read_addr got=%h want=%h", mem_addr, 32'h40);
                end
            end
            if (k == 5) i_req = 1'b0;
        end
    endtask

    task automatic test_write();
        int g;
        g = gcyc;
        d_addr = 32'h100; d_wdata = 32'h12345678; d_we = 1'b1; d_req = 1'b1;
        sbq.push_back('{1'b1, 1'b0, 32'h0, g + 5});
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if ({d_grant, busy, mem_we, i_grant} !== {k <= 5, k <= 5, k == 1, 1'b0}) begin
                errors++;
                $display("FAIL write_ctl k=%0d got=%b want=%b", k,
                         {d_grant, busy, mem_we, i_grant}, {k <= 5, k <= 5, k == 1, 1'b0});
            end
            if (k == 1) begin
                checks++;
                if (mem_addr !== 32'h100 || mem_wdata !== 32'h12345678) begin
                    errors++;
                    $display("FAIL write_bus got=%h/%h want=00000100/12345678",
                             mem_addr, mem_wdata);
                end
                ref_mem[64] = 32'h12345678;
            end
            if (k == 5) begin d_req = 1'b0; d_we = 1'b0; end
        end
        g = gcyc;
        d_req = 1'b1;
        sbq.push_back('{1'b1, 1'b1, ref_mem[64], g + 5});
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (mem_we !== 1'b0) begin
                errors++;
                $display("FAIL readback_we k=%0d got=%b want=0", k, mem_we);
            end
            if (k == 5) d_req = 1'b0;
        end
    endtask

    task automatic test_tie();
        int g;
        logic wi, wd;
        rst = 1'b1;
        step();
        rst = 1'b0;
        g = gcyc;
        i_addr = 32'h40; d_addr = 32'h100; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        sbq.push_back('{1'b0, 1'b1, ref_mem[16], g + 5});
        sbq.push_back('{1'b1, 1'b1, ref_mem[64], g + 11});
        sbq.push_back('{1'b0, 1'b1, ref_mem[16], g + 17});
        for (int k = 1; k <= 19; k++) begin
            step();
            wi = (k <= 5) || (k >= 13 && k <= 17);
            wd = (k >= 7 && k <= 11);
            checks++;
            if ({i_grant, d_grant} !== {wi, wd}) begin
                errors++;
                $display("FAIL tie_grant k=%0d got=%b want=%b", k,
                         {i_grant, d_grant}, {wi, wd});
            end
            if (k == 8) begin
                checks++;
                if (mem_addr !== 32'h100) begin
                    errors++;
                    $display("FAIL tie_addr got=%h want=00000100", mem_addr);
                end
            end
            if (k == 17) begin i_req = 1'b0; d_req = 1'b0; end
        end
    endtask

    task automatic test_late_req();
        int g;
        logic wi, wd;
        g = gcyc;
        i_addr = 32'h40; i_req = 1'b1;
        d_addr = 32'h100; d_we = 1'b0;
        sbq.push_back('{1'b0, 1'b1, ref_mem[16], g + 5});
        for (int k = 1; k <= 12; k++) begin
            step();
            wi = (k <= 5);
            wd = (k >= 7 && k <= 11);
            checks++;
            if ({i_grant, d_grant, busy} !== {wi, wd, wi || wd}) begin
                errors++;
                $display("FAIL late_grant k=%0d got=%b want=%b", k,
                         {i_grant, d_grant, busy}, {wi, wd, wi || wd});
            end
            if (k == 2) begin
                d_req = 1'b1;
                sbq.push_back('{1'b1, 1'b1, ref_mem[64], g + 11});
            end
            if (k == 5) i_req = 1'b0;
            if (k == 11) d_req = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int g;
        logic wi;
        g = gcyc;
        i_addr = 32'h40; i_req = 1'b1;
        sbq.push_back('{1'b0, 1'b1, ref_mem[16], g + 5});
        sbq.push_back('{1'b0, 1'b1, ref_mem[16], g + 11});
        for (int k = 1; k <= 12; k++) begin
            step();
            wi = (k <= 5) || (k >= 7 && k <= 11);
            checks++;
            if ({i_grant, d_grant} !== {wi, 1'b0}) begin
                errors++;
                $display("FAIL b2b_grant k=%0d got=%b want=%b", k,
                         {i_grant, d_grant}, {wi, 1'b0});
            end
            if (k == 11) i_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int g;
        d_addr = 32'h80; d_wdata = 32'hA5A5A5A5; d_we = 1'b1; d_req = 1'b1;
        step();
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_we got=%b want=1", mem_we);
        end
        ref_mem[32] = 32'hA5A5A5A5;
        step();
        rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
        step();
        rst = 1'b0;
        checks++;
        if ({i_grant, d_grant, i_done, d_done, mem_we, busy} !== 6'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_out got=%b/%h/%h/%h want=0",
                     {i_grant, d_grant, i_done, d_done, mem_we, busy},
                     mem_addr, mem_wdata, d_rdata);
        end
        for (int k = 4; k <= 6; k++) begin
            step();
            checks++;
            if ({d_grant, d_done, mem_we, busy} !== 4'b0) begin
                errors++;
                $display("FAIL rstmid_quiet k=%0d got=%b want=0000", k,
                         {d_grant, d_done, mem_we, busy});
            end
        end
        g = gcyc;
        i_addr = 32'h80; i_req = 1'b1;
        sbq.push_back('{1'b0, 1'b1, ref_mem[32], g + 5});
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (i_grant !== (k <= 5)) begin
                errors++;
                $display("FAIL rstmid_after k=%0d got=%b want=%b", k, i_grant, k <= 5);
            end
            if (k == 5) i_req = 1'b0;
        end
    endtask

    task automatic test_lat1();
        i_addr1 = 32'h44; i_req1 = 1'b1; mem_rdata1 = 32'h0BADF00D;
        step();
        checks++;
        if ({i_grant1, busy1, i_done1} !== 3'b110 || mem_addr1 !== 32'h44) begin
            errors++;
            $display("FAIL lat1_acc got=%b/%h want=110/00000044",
                     {i_grant1, busy1, i_done1}, mem_addr1);
        end
        mem_rdata1 = 32'h11112222;
        step();
        checks++;
        if ({i_grant1, i_done1, d_done1} !== 3'b110 || i_rdata1 !== 32'h11112222) begin
            errors++;
            $display("FAIL lat1_done got=%b/%h want=110/11112222",
                     {i_grant1, i_done1, d_done1}, i_rdata1);
        end
        mem_rdata1 = 32'h33334444; i_req1 = 1'b0;
        step();
        checks++;
        if ({i_grant1, busy1, i_done1} !== 3'b000 || i_rdata1 !== 32'h11112222) begin
            errors++;
            $display("FAIL lat1_idle got=%b/%h want=000/11112222",
                     {i_grant1, busy1, i_done1}, i_rdata1);
        end
        d_addr1 = 32'h200; d_wdata1 = 32'hFEEDFACE; d_we1 = 1'b1; d_req1 = 1'b1;
        step();
        checks++;
        if ({d_grant1, mem_we1} !== 2'b11 || mem_addr1 !== 32'h200 ||
            mem_wdata1 !== 32'hFEEDFACE) begin
            errors++;
            $display("FAIL lat1_wr got=%b/%h/%h want=11/00000200/feedface",
                     {d_grant1, mem_we1}, mem_addr1, mem_wdata1);
        end
        step();
        checks++;
        if ({d_done1, mem_we1, i_done1} !== 3'b100) begin
            errors++;
            $display("FAIL lat1_wrdone got=%b want=100", {d_done1, mem_we1, i_done1});
        end
        d_req1 = 1'b0; d_we1 = 1'b0;
        step();
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL lat1_end got=%b want=0", busy1);
        end
    endtask

    task automatic test_drain();
        step(); step();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got=%0d pending want=0", sbq.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE0000 | 32'(i);
        ref_mem[16] = 32'hDEADBEEF;
        rst = 1'b1; mem_clr = 1'b1;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0;
        i_req1 = 1'b0; i_addr1 = '0; d_req1 = 1'b0; d_we1 = 1'b0;
        d_addr1 = '0; d_wdata1 = '0; mem_rdata1 = '0;
        test_reset();
        test_single_read();
        test_write();
        test_tie();
        test_late_req();
        test_back_to_back();
        test_reset_mid();
        test_lat1();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
